// File: rtl/ring_output_arbiter.sv
// Ring output link arbiter: polarity-gated per-VC round-robin between ring pass-through and PE injection.
// Optional statistics counters are enabled by defining RING_ARB_STATS_EN.
module ring_output_arbiter #(
  parameter int unsigned PAC_SIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  output logic                polarity,
  input  logic                ring_valid,
  input  logic [PAC_SIZE-1:0] ring_data,
  output logic                ring_pop,
  input  logic                pe_valid,
  input  logic [PAC_SIZE-1:0] pe_data,
  output logic                pe_pop,
  input  logic [1:0]          out_ready,
  output logic                out_valid,
  output logic [PAC_SIZE-1:0] out_data
`ifdef RING_ARB_STATS_EN
  ,
  output logic [31:0]         ring_grant_cnt,
  output logic [31:0]         pe_grant_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int unsigned VC_BIT = PAC_SIZE - 1;

  // rr[v]: 0 prefers ring, 1 prefers PE for VC v
  logic [1:0] rr;
  logic       ring_match;
  logic       pe_match;
  logic       ring_elig;
  logic       pe_elig;

  // Eligibility and grant decision for the VC matching the current polarity
  always_comb begin
    ring_match = ring_valid && (ring_data[VC_BIT] == polarity);
    pe_match   = pe_valid && (pe_data[VC_BIT] == polarity);
    ring_elig  = 1'b0;
    pe_elig    = 1'b0;
    ring_pop   = 1'b0;
    pe_pop     = 1'b0;
    if (!reset && out_ready[polarity]) begin
      ring_elig = ring_match;
      pe_elig   = pe_match;
      ring_pop  = ring_elig && (!pe_elig || !rr[polarity]);
      pe_pop    = pe_elig && !ring_pop;
    end
  end

  // Polarity, fairness pointers and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity  <= 1'b0;
      rr        <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      polarity  <= ~polarity;
      out_valid <= ring_pop | pe_pop;
      if (ring_pop) begin
        out_data     <= ring_data;
        rr[polarity] <= 1'b1;
      end else if (pe_pop) begin
        out_data     <= pe_data;
        rr[polarity] <= 1'b0;
      end
    end
  end

`ifdef RING_ARB_STATS_EN
  localparam int unsigned CNT_W = 32;

  logic stall_c;

  always_comb begin
    stall_c = !reset && !out_ready[polarity] && (ring_match || pe_match);
  end

  // Saturating grant and stall counters
  always_ff @(posedge clk) begin
    if (reset) begin
      ring_grant_cnt <= '0;
      pe_grant_cnt   <= '0;
      stall_cnt      <= '0;
    end else begin
      if (ring_pop && (ring_grant_cnt != '1)) ring_grant_cnt <= ring_grant_cnt + CNT_W'(1);
      if (pe_pop && (pe_grant_cnt != '1))     pe_grant_cnt   <= pe_grant_cnt + CNT_W'(1);
      if (stall_c && (stall_cnt != '1))       stall_cnt      <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/ring_output_arbiter.md
Name: ring_output_arbiter

Overview:
- Arbitrates one outgoing ring link (e.g. the clockwise output) of a NoC ring router node between two requesters:
  - the pass-through ring traffic from the upstream input buffer;
  - the local PE injection buffer.
- Owns the node's even/odd polarity and allows only packets of the virtual channel (VC) matching the current polarity onto the link.
- Applies per-VC round-robin fairness and registers the winning packet onto the link.

Parameters:
- PAC_SIZE, 64, packet width. Bit PAC_SIZE-1 = vc, bit PAC_SIZE-2 = dir, bits [PAC_SIZE-9:PAC_SIZE-16] = hop field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- polarity  out  1  current node polarity; also the VC being served this cycle.
- ring_valid  in  1  upstream ring buffer holds a packet.
- ring_data  in  PAC_SIZE  head packet of upstream ring buffer.
- ring_pop  out  1  ring head consumed this cycle (combinational).
- pe_valid  in  1  PE injection buffer holds a packet.
- pe_data  in  PAC_SIZE  head packet of PE injection buffer.
- pe_pop  out  1  PE head consumed this cycle (combinational).
- out_ready  in  2  downstream buffer has space, indexed by VC.
- out_valid  out  1  link carries a packet this cycle (registered).
- out_data  out  PAC_SIZE  link packet (registered).

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on port reset.
  - While reset=1 at a posedge: polarity=0, out_valid=0, out_data=0, both RR pointers=0 (ring preferred).
  - ring_pop=0 and pe_pop=0 whenever reset=1.
  - Reset asserted mid-operation discards any registered packet; nothing is popped in that cycle.
- Polarity:
  - Toggles every clock after reset releases: 0,1,0,1…
  - First post-reset cycle has polarity=0.
- Eligibility:
  - A requester X is eligible when X_valid=1, X_data[PAC_SIZE-1]==polarity, and out_ready[polarity]=1.
  - A requester whose VC mismatches polarity waits; it is never reordered or dropped.
- Grant selection:
  - Two requesters, one per-VC pointer rr[polarity]: 0 prefers ring, 1 prefers PE.
  - Only one eligible: grant it.
  - Both eligible: grant the preferred one.
  - After any grant on VC v, rr[v] points to the non-granted requester. rr of the other VC is untouched.
  - No eligible requester: no grant; pointers hold.
- Pop timing:
  - Pop outputs are combinational in the decision cycle: X_pop=1 exactly when X is granted.
  - The requester buffer advances at the same posedge.
- Output stage:
  - On the posedge ending a grant cycle: out_valid<=1, out_data<=granted data, unmodified.
  - Otherwise out_valid<=0 and out_data holds its previous value.
  - Latency: one cycle from grant to out_valid.
  - The out_data VC bit always equals the polarity of the previous cycle.
- Downstream rule: out_ready is sampled only in the decision cycle; downstream must accept every asserted out_valid.
- Sustained traffic:
  - At most one packet per cycle.
  - Sustained same-VC traffic alternates grants at most every 2 cycles, because each VC is served only on every other cycle.
- Boundaries:
  - Both valid but out_ready[polarity]=0: no pop, no pointer change.
  - A valid that drops before its VC's turn produces no side effect.

Optional Feature:
- Macro RING_ARB_STATS_EN.
- When defined, adds output ports:
  - ring_grant_cnt (32 bits): counts ring grants.
  - pe_grant_cnt (32 bits): counts PE grants.
  - stall_cnt (32 bits): counts cycles where at least one requester with a matching VC was valid but out_ready[polarity]=0.
- All three counters are saturating at 32'hFFFFFFFF and clear on reset.
- When undefined, these ports and their logic do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset, then idle: polarity toggles 0,1,0,1 from the first post-reset cycle; out_valid=0; no pops for 10 cycles.
- Single PE packet 64'h0001_0001_0000_0002 (vc=0), injected during a polarity=1 cycle: pe_valid is held; pe_pop=1 in the next cycle (polarity=0); out_valid=1 with identical data one cycle later.
- Ring and PE both continuously valid with vc=0 packets, out_ready=2'b11: grants alternate ring, PE, ring, PE on successive polarity-0 cycles; ring goes first after reset; no two pops in the same cycle.
- Ring vc=1 packet and PE vc=0 packet both valid: each is granted in its own polarity cycle; the VC1 pointer is unaffected by VC0 grants.
- out_ready=2'b10 with a vc=0 ring packet valid: no pop for 6 cycles; raising out_ready[0] gives a grant on the next polarity-0 cycle. With RING_ARB_STATS_EN defined, stall_cnt=3 after 6 cycles.
- Assert reset while out_valid=1: at the next posedge, out_valid=0, polarity=0, pointers cleared; the pending requester is re-arbitrated from scratch after release.
